// File: rtl/sff_piso_tx.sv
// ============================================================================
//  Module   : sff_piso_tx
//  Brief    : Parallel-in/serial-out transmitter with valid/ready intake and
//             gap-free back-to-back frames. Optional trailing even-parity bit
//             enabled by macro SFF_PISO_TX_PARITY_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sff_piso_tx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             ck,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             q,
  output logic             q_en,
  output logic             busy,
  output logic             done
);

`ifdef SFF_PISO_TX_PARITY_EN
  localparam int c_frame_len = WIDTH + 1;
`else
  localparam int c_frame_len = WIDTH;
`endif
  localparam int                 c_cnt_w   = $clog2(WIDTH + 1);
  localparam logic [c_cnt_w-1:0] c_last    = c_cnt_w'(c_frame_len - 1);
  localparam logic [c_cnt_w-1:0] c_prelast = c_cnt_w'(c_frame_len - 2);
  localparam logic [c_cnt_w-1:0] c_one     = c_cnt_w'(1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t                 r_state;
  logic [c_cnt_w-1:0]     r_count;
  logic [c_frame_len-2:0] r_shreg;
  logic                   r_q;
  logic                   r_q_en;
  logic                   r_busy;
  logic                   r_done;

  logic [WIDTH-1:0]       w_ordered;
  logic [c_frame_len-1:0] w_frame;
  logic                   w_last_bit;
  logic                   w_accept;

  // w_ordered[0] is always the first bit on the line.
  generate
    if (MSB_FIRST) begin : g_msb_first
      for (genvar i = 0; i < WIDTH; i++) begin : g_rev
        assign w_ordered[i] = din[WIDTH-1-i];
      end
    end else begin : g_lsb_first
      assign w_ordered = din;
    end
  endgenerate

`ifdef SFF_PISO_TX_PARITY_EN
  assign w_frame = {^din, w_ordered};
`else
  assign w_frame = w_ordered;
`endif

  assign w_last_bit = (r_state == S_SHIFT) && (r_count == c_last);
  assign din_ready  = (r_state == S_IDLE) || w_last_bit;
  assign w_accept   = din_valid && din_ready;

  always_ff @(posedge ck) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_shreg <= '0;
      r_q     <= 1'b0;
      r_q_en  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else if (w_accept) begin
      // Accept from IDLE or in the last-bit cycle: first bit goes out next cycle.
      r_state <= S_SHIFT;
      r_count <= '0;
      r_q     <= w_frame[0];
      r_shreg <= w_frame[c_frame_len-1:1];
      r_q_en  <= 1'b1;
      r_busy  <= 1'b1;
      r_done  <= 1'b0;
    end else if (r_state == S_SHIFT) begin
      if (w_last_bit) begin
        r_state <= S_IDLE;
        r_count <= '0;
        r_q     <= 1'b0;
        r_q_en  <= 1'b0;
        r_busy  <= 1'b0;
        r_done  <= 1'b0;
      end else begin
        r_count <= r_count + c_one;
        r_q     <= r_shreg[0];
        r_shreg <= r_shreg >> 1;
        r_done  <= (r_count == c_prelast);
      end
    end
  end

  assign q    = r_q;
  assign q_en = r_q_en;
  assign busy = r_busy;
  assign done = r_done;

endmodule

`default_nettype wire

// File: tb/tb_sff_piso_tx.sv
// ============================================================================
//  Module   : tb_sff_piso_tx
//  Brief    : Self-checking bench for sff_piso_tx, MSB-first and LSB-first
//             instances side by side against a bit-order reference model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sff_piso_tx;

  localparam int W = 8;
`ifdef SFF_PISO_TX_PARITY_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] din;
  logic         din_valid;

  logic rdy_m, q_m, qen_m, busy_m, done_m;
  logic rdy_l, q_l, qen_l, busy_l, done_l;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  sff_piso_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .ck(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .din_ready(rdy_m), .q(q_m), .q_en(qen_m), .busy(busy_m), .done(done_m)
  );

  sff_piso_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .ck(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .din_ready(rdy_l), .q(q_l), .q_en(qen_l), .busy(busy_l), .done(done_l)
  );

  // Reference: bit idx of a frame (idx == W is the parity bit).
  function automatic logic exp_bit(input logic [W-1:0] w, input int idx, input bit msb);
    if (idx >= W) return ^w;
    return msb ? w[W-1-idx] : w[idx];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Observed/expected vectors are {q, q_en, busy, done, din_ready}.
  task automatic test_reset();
    logic [4:0] obs;
    rst = 1'b1; din_valid = 1'b1; din = 8'hA5;
    step(); step();
    obs = {q_m, qen_m, busy_m, done_m, rdy_m};
    n_total++;
    if (obs !== 5'b00001) $display("FAIL reset_msb obs=%b exp=%b", obs, 5'b00001);
    else n_pass++;
    obs = {q_l, qen_l, busy_l, done_l, rdy_l};
    n_total++;
    if (obs !== 5'b00001) $display("FAIL reset_lsb obs=%b exp=%b", obs, 5'b00001);
    else n_pass++;
    rst = 1'b0; din_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      obs = {q_m | q_l, qen_m | qen_l, busy_m | busy_l, done_m | done_l, rdy_m & rdy_l};
      n_total++;
      if (obs !== 5'b00001) $display("FAIL post_reset_idle k=%0d obs=%b exp=%b", k, obs, 5'b00001);
      else n_pass++;
    end
  endtask

  // Isolated frames with idle gaps; din_valid toggles randomly mid-frame with junk din.
  task automatic test_single();
    logic [W-1:0] words[$];
    logic [4:0]   obs, expv;
    words = '{8'hA5, 8'h01, 8'h07, 8'hF0};
    for (int i = 0; i < 4; i++) words.push_back(W'($urandom));
    foreach (words[i]) begin
      din = words[i]; din_valid = 1'b1;
      step();
      for (int k = 0; k < FL; k++) begin
        expv = {exp_bit(words[i], k, 1'b1), 1'b1, 1'b1, k == FL-1, k == FL-1};
        obs  = {q_m, qen_m, busy_m, done_m, rdy_m};
        n_total++;
        if (obs !== expv) $display("FAIL single_msb w=%h k=%0d obs=%b exp=%b", words[i], k, obs, expv);
        else n_pass++;
        expv = {exp_bit(words[i], k, 1'b0), 1'b1, 1'b1, k == FL-1, k == FL-1};
        obs  = {q_l, qen_l, busy_l, done_l, rdy_l};
        n_total++;
        if (obs !== expv) $display("FAIL single_lsb w=%h k=%0d obs=%b exp=%b", words[i], k, obs, expv);
        else n_pass++;
        din       = W'($urandom);
        din_valid = (k == FL-1) ? 1'b0 : 1'($urandom);
        step();
      end
      obs = {q_m | q_l, qen_m | qen_l, busy_m | busy_l, done_m | done_l, rdy_m & rdy_l};
      n_total++;
      if (obs !== 5'b00001) $display("FAIL single_idle w=%h obs=%b exp=%b", words[i], obs, 5'b00001);
      else n_pass++;
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] words[$];
    logic [4:0]   obs, expv;
    int           n;
    words = '{8'hFF, 8'h00};
    for (int i = 0; i < 4; i++) words.push_back(W'($urandom));
    n = words.size();
    din = words[0]; din_valid = 1'b1;
    step();
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < FL; k++) begin
        expv = {exp_bit(words[i], k, 1'b1), 1'b1, 1'b1, k == FL-1, k == FL-1};
        obs  = {q_m, qen_m, busy_m, done_m, rdy_m};
        n_total++;
        if (obs !== expv) $display("FAIL b2b_msb f=%0d k=%0d obs=%b exp=%b", i, k, obs, expv);
        else n_pass++;
        expv = {exp_bit(words[i], k, 1'b0), 1'b1, 1'b1, k == FL-1, k == FL-1};
        obs  = {q_l, qen_l, busy_l, done_l, rdy_l};
        n_total++;
        if (obs !== expv) $display("FAIL b2b_lsb f=%0d k=%0d obs=%b exp=%b", i, k, obs, expv);
        else n_pass++;
        // Valid stays high throughout; only the last-bit cycle may accept.
        if (k == FL-1) begin
          din_valid = (i < n-1);
          din       = (i < n-1) ? words[i+1] : W'($urandom);
        end else begin
          din_valid = 1'b1;
          din       = W'($urandom);
        end
        step();
      end
    end
    obs = {q_m | q_l, qen_m | qen_l, busy_m | busy_l, done_m | done_l, rdy_m & rdy_l};
    n_total++;
    if (obs !== 5'b00001) $display("FAIL b2b_idle obs=%b exp=%b", obs, 5'b00001);
    else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    logic [W-1:0] w;
    logic [4:0]   obs, expv;
    din = 8'hF0; din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    for (int k = 0; k < 3; k++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      obs = {q_m | q_l, qen_m | qen_l, busy_m | busy_l, done_m | done_l, rdy_m & rdy_l};
      n_total++;
      if (obs !== 5'b00001) $display("FAIL abort_idle k=%0d obs=%b exp=%b", k, obs, 5'b00001);
      else n_pass++;
      step();
    end
    w = W'($urandom);
    din = w; din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    for (int k = 0; k < FL; k++) begin
      expv = {exp_bit(w, k, 1'b1), 1'b1, 1'b1, k == FL-1, k == FL-1};
      obs  = {q_m, qen_m, busy_m, done_m, rdy_m};
      n_total++;
      if (obs !== expv) $display("FAIL after_abort_msb w=%h k=%0d obs=%b exp=%b", w, k, obs, expv);
      else n_pass++;
      expv = {exp_bit(w, k, 1'b0), 1'b1, 1'b1, k == FL-1, k == FL-1};
      obs  = {q_l, qen_l, busy_l, done_l, rdy_l};
      n_total++;
      if (obs !== expv) $display("FAIL after_abort_lsb w=%h k=%0d obs=%b exp=%b", w, k, obs, expv);
      else n_pass++;
      step();
    end
    obs = {q_m | q_l, qen_m | qen_l, busy_m | busy_l, done_m | done_l, rdy_m & rdy_l};
    n_total++;
    if (obs !== 5'b00001) $display("FAIL after_abort_idle obs=%b exp=%b", obs, 5'b00001);
    else n_pass++;
  endtask

  initial begin
    rst = 1'b1; din = '0; din_valid = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
